seven_seg_scan_ctrl: RTL

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display. It owns the refresh timebase, selects one digit at a time, and drives the anode and nibble lines that feed the existing hex-to-segment decoder. New display values arrive over a valid/ready handshake and are committed only at a scan-frame boundary, so no frame ever shows a mix of old and new digits. Optional leading-zero blanking and a per-digit decimal point are included.

---
 rtl/seven_seg_pkg.sv | 33 +++
 rtl/refresh_prescaler.sv | 39 +++
 rtl/seven_seg_scan_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
//   Shared types, constants and helpers for the seven-segment display path.
//   - DIGIT_W     : width of one hex digit nibble.
//   - MAX_DIGITS  : widest display the helpers below support.
//   - ANODE_OFF   : all-ones anode pattern (every digit dark); slice to width.
//   - digit_t     : one hex nibble as fed to the hex-to-segment decoder.
//   - nibble_sel  : pick nibble 'idx' out of a packed digit vector.
// ---------------------------------------------------------------------------
package seven_seg_pkg;

  localparam int DIGIT_W     = 4;
  localparam int MAX_DIGITS  = 16;
  localparam int MAX_VALUE_W = MAX_DIGITS * DIGIT_W;

  // Anodes are active-low, so all ones means every digit is off.
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Returns nibble 'idx' of 'value' (nibble 0 in bits [3:0]). The loop keeps
  // every part-select constant, so this maps to a plain mux.
  function automatic digit_t nibble_sel(input logic [MAX_VALUE_W-1:0] value,
                                        input int                      idx);
    digit_t sel;
    sel = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i == idx) sel = value[i*DIGIT_W +: DIGIT_W];
    end
    return sel;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// ---------------------------------------------------------------------------
// refresh_prescaler
//   Free-running divider producing a one-cycle tick every DIV clocks. Also
//   intended as the timebase for the button debouncer.
//   Parameters:
//     DIV   : clk cycles per tick, 2 or more.
//   Ports:
//     clk   : system clock.
//     rst_n : asynchronous active-low reset, count returns to 0.
//     tick  : high while the count sits at DIV-1 (last cycle of the period).
// ---------------------------------------------------------------------------
module refresh_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
//   Time-multiplexed scan controller for a common-anode seven-segment display.
//   One digit is lit per REFRESH_DIV-cycle slot. New display data arrives
//   over valid/ready into a single pending slot and is copied to the active
//   register only at the end of a scan frame, so a frame never mixes old and
//   new digits. Optional leading-zero blanking and per-digit decimal points.
//   Parameters:
//     NUM_DIGITS  : number of multiplexed digits (up to MAX_DIGITS).
//     REFRESH_DIV : clk cycles per digit slot, 2 or more.
//     LEAD_BLANK  : 1 blanks leading zero digits; digit 0 is always shown.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset.
//     enable         : low forces every anode (and dp) off; scan keeps running.
//     value          : digit nibbles, digit 0 in bits [3:0].
//     dp_mask        : decimal point enables, bit i for digit i, 1 = lit.
//     value_valid    : requester offers value/dp_mask.
//     value_ready    : pending slot is empty.
//     anode_activate : active-low digit enables (registered).
//     led_binary     : nibble for the hex-to-segment decoder (registered).
//     dp             : active-low decimal point (registered).
//     frame_pulse    : one-cycle strobe, one cycle after each frame end.
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int LEAD_BLANK  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic                          value_valid,
  output logic                          value_ready,
  output logic [NUM_DIGITS-1:0]         anode_activate,
  output digit_t                        led_binary,
  output logic                          dp,
  output logic                          frame_pulse
);

  localparam int VALUE_W = DIGIT_W * NUM_DIGITS;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX      = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_ALL_OFF = ANODE_OFF[NUM_DIGITS-1:0];

  // -------------------------------------------------------------------------
  // Timebase and digit index
  // -------------------------------------------------------------------------
  logic             tick;
  logic             frame_end;
  logic [IDX_W-1:0] idx;

  refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign frame_end = tick && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Handshake: one pending slot, committed to active only at frame_end
  // -------------------------------------------------------------------------
  logic                  pend_valid;
  logic [VALUE_W-1:0]    pend_value;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [VALUE_W-1:0]    active_value;
  logic [NUM_DIGITS-1:0] active_dp;
  logic                  transfer;
  logic                  commit;

  assign value_ready = !pend_valid;
  assign transfer    = value_valid && !pend_valid;
  // commit needs a full slot while transfer needs an empty one, so data
  // accepted in a frame_end cycle waits for the following frame_end.
  assign commit      = frame_end && pend_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid   <= 1'b0;
      active_value <= '0;
      active_dp    <= '0;
    end else if (commit) begin
      pend_valid   <= 1'b0;
      active_value <= pend_value;
      active_dp    <= pend_dp;
    end else if (transfer) begin
      pend_valid   <= 1'b1;
    end
  end

  // NOTE: the pending data registers carry no reset; pend_valid alone says
  // whether they hold anything, so resetting them would only add reset fanout.
  always_ff @(posedge clk) begin
    if (transfer) begin
      pend_value <= value;
      pend_dp    <= dp_mask;
    end
  end

  // -------------------------------------------------------------------------
  // Leading-zero blanking over the active value
  // -------------------------------------------------------------------------
  // Digit i > 0 is visible when any nibble from i up to the top is nonzero.
  function automatic logic [NUM_DIGITS-1:0] visible_digits(
    input logic [VALUE_W-1:0] v
  );
    logic [NUM_DIGITS-1:0] vis;
    logic                  seen;
    vis  = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen   = seen | (v[i*DIGIT_W +: DIGIT_W] != '0);
      vis[i] = seen || (LEAD_BLANK == 0);
    end
    vis[0] = 1'b1;
    return vis;
  endfunction

  // -------------------------------------------------------------------------
  // Output decode (registered below)
  // -------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] shown;
  logic                  digit_on;
  logic [NUM_DIGITS-1:0] anode_next;
  digit_t                nibble_next;
  logic                  dp_next;

  // NOTE: every always_comb output gets a default before any conditional
  // write, so no path leaves a value held and no latch is inferred.
  always_comb begin
    shown       = visible_digits(active_value);
    digit_on    = enable && shown[idx];
    anode_next  = ANODE_ALL_OFF;
    dp_next     = 1'b1;
    nibble_next = nibble_sel(MAX_VALUE_W'(active_value), int'(idx));
    if (digit_on) begin
      anode_next[idx] = 1'b0;
      dp_next         = ~active_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_activate <= ANODE_ALL_OFF;
      led_binary     <= '0;
      dp             <= 1'b1;
      frame_pulse    <= 1'b0;
    end else begin
      anode_activate <= anode_next;
      led_binary     <= nibble_next;
      dp             <= dp_next;
      frame_pulse    <= frame_end;
    end
  end

endmodule
